dmem_resp: RTL

- Data-memory responder: the memory-side end of the processor's request/ready/valid data-memory handshake.
- Accepts one word read or write from the core's MEM stage, holds it for a programmable latency, then returns read data or a write acknowledgement with a one-cycle valid pulse.
- Used as the data memory in core-level simulation and FPGA builds.
- Its variable latency is what exercises the core's memory-stall path.

---
 rtl/dmem_pkg.sv | 43 ++++
 rtl/dmem_if.sv | 31 +++
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_resp.sv | 117 +++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared constants, FSM state encodings and the word-index
//                helper for the data-memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Width of the latency down-counter (covers LATENCY up to 15)
    localparam int c_CNT_W = 4;

    // FSM state encodings
    localparam int         c_ST_W = 2;
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    // Result of an address decode: word index plus in-range flag
    typedef struct packed {
        logic        in_range;
        logic [63:0] index;
    } word_index_t;

    // Word index = (addr - base) >> 2, wrapped at the bus width so that an
    // address below the base becomes a huge index and is rejected by the
    // unsigned compare against the depth.
    function automatic word_index_t word_index(input logic [63:0] addr,
                                               input logic [63:0] base,
                                               input logic [63:0] depth,
                                               input int          nbits);
        word_index_t res;
        logic [63:0] mask;
        logic [63:0] diff;
        mask         = (nbits >= 64) ? {64{1'b1}} : ((64'd1 << nbits) - 64'd1);
        diff         = (addr - base) & mask;
        res.index    = diff >> 2;
        res.in_range = (res.index < depth);
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_if
//  Description : Request/ready/valid data-memory handshake between the core's
//                MEM stage (master) and the memory responder (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_if #(
    parameter int NBITS = 32
);
    logic             proc_req;
    logic             we;
    logic [NBITS-1:0] addr;
    logic [NBITS-1:0] wdata;
    logic             hold;
    logic             mem_rdy;
    logic             valid;
    logic [NBITS-1:0] rdata;
    logic             err;

    modport master (
        output proc_req, we, addr, wdata, hold,
        input  mem_rdy, valid, rdata, err
    );

    modport slave (
        input  proc_req, we, addr, wdata, hold,
        output mem_rdy, valid, rdata, err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : DEPTH x NBITS storage, synchronous write and synchronous read
//                sharing one address. No reset. Read-during-write returns the
//                new data. The read register only updates when re is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int NBITS = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  wire logic             clk,
    input  wire logic             we,
    input  wire logic             re,
    input  wire logic [AW-1:0]    addr,
    input  wire logic [NBITS-1:0] wdata,
    output logic      [NBITS-1:0] q
);
    logic [NBITS-1:0] r_mem [DEPTH];

    // Write port and enabled read register (write-first on collision)
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        if (re) begin
            q <= we ? wdata : r_mem[addr];
        end
    end
endmodule
`default_nettype wire

// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_resp
//  Description : Memory-side end of the data-memory handshake. Accepts one
//                word access in IDLE, waits a programmable latency, then
//                pulses valid (with err for out-of-range accesses).
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int               NBITS     = 32,
    parameter int               DEPTH     = 1024,
    parameter int               LATENCY   = 2,
    parameter logic [NBITS-1:0] BASE_ADDR = '0
) (
    input  wire logic clk,
    input  wire logic rst,      // synchronous, active low
    dmem_if.slave     bus
);
    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD =
        (LATENCY >= 2) ? c_CNT_W'(LATENCY - 2) : '0;

    // Elaboration-time parameter sanity checks
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $fatal(1, "dmem_resp: LATENCY must be in 1..15");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "dmem_resp: DEPTH must be a power of two");
    end

    logic [c_ST_W-1:0]  r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_oor;      // latched out-of-range flag
    logic               r_rd_ok;    // rdata register holds a valid read word
    word_index_t        w_wi;
    logic               w_in_range;
    logic [c_AW-1:0]    w_idx;
    logic               w_accept;
    logic               w_arr_we;
    logic               w_arr_re;
    logic [NBITS-1:0]   w_arr_q;

    // Address decode; the upper-bit test is implied by in_range but keeps the
    // truncated array index provably within bounds.
    assign w_wi       = word_index(64'(bus.addr), 64'(BASE_ADDR), 64'(DEPTH), NBITS);
    assign w_in_range = w_wi.in_range && (w_wi.index[63:c_AW] == '0);
    assign w_idx      = w_wi.index[c_AW-1:0];

    // Acceptance is suppressed while reset is asserted
    assign w_accept = rst && (r_state == c_IDLE) && bus.proc_req;
    assign w_arr_we = w_accept &&  bus.we && w_in_range;
    assign w_arr_re = w_accept && !bus.we && w_in_range;

    dmem_array #(
        .NBITS (NBITS),
        .DEPTH (DEPTH),
        .AW    (c_AW)
    ) u_array (
        .clk   (clk),
        .we    (w_arr_we),
        .re    (w_arr_re),
        .addr  (w_idx),
        .wdata (bus.wdata),
        .q     (w_arr_q)
    );

    // Handshake FSM, latency counter and request flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_oor   <= 1'b0;
            r_rd_ok <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_oor <= !w_in_range;
                        if (!bus.we) begin
                            r_rd_ok <= w_in_range;
                        end
                        if (LATENCY == 1) begin
                            r_state <= c_RESP;
                        end else begin
                            r_cnt   <= c_CNT_LOAD;
                            r_state <= c_WAIT;
                        end
                    end
                end
                c_WAIT: begin
                    if (!bus.hold) begin
                        if (r_cnt == '0) begin
                            r_state <= c_RESP;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rdy = (r_state == c_IDLE);
    assign bus.valid   = (r_state == c_RESP);
    assign bus.err     = (r_state == c_RESP) && r_oor;
    // Out-of-range reads and the post-reset state both present zero
    assign bus.rdata   = r_rd_ok ? w_arr_q : '0;
endmodule
`default_nettype wire
